// File: rtl/ysyx_idu_pkg.sv
// Shared decode constants for the IDU: RV32I opcodes, ALU op encodings, FSM states, ctl bits.
package ysyx_idu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9,
        AluLui  = 4'd10
    } alu_op_e;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Bit positions inside ctl_o, MSB first: load, store, branch, jal, jalr, auipc, ebreak, ecall.
    localparam int unsigned CTL_LOAD   = 7;
    localparam int unsigned CTL_STORE  = 6;
    localparam int unsigned CTL_BRANCH = 5;
    localparam int unsigned CTL_JAL    = 4;
    localparam int unsigned CTL_JALR   = 3;
    localparam int unsigned CTL_AUIPC  = 2;
    localparam int unsigned CTL_EBREAK = 1;
    localparam int unsigned CTL_ECALL  = 0;

    // alt selects SUB/SRA over ADD/SRL (inst[30] for the encodings that allow it).
    function automatic alu_op_e alu_from_funct(logic [2:0] f3, logic alt);
        unique case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_idu_dec.sv
// Purely combinational RV32I/E decoder: raw instruction -> register indices, immediate,
// ALU op, control flags and an illegal-instruction indication.
module ysyx_idu_dec
    import ysyx_idu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic [DATA_W-1:0] inst,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rs2,
    output logic [DATA_W-1:0] imm,
    output logic [3:0]        alu_op,
    output logic [2:0]        funct3,
    output logic              wen,
    output logic [7:0]        ctl,
    output logic              illegal
);

    localparam bit RvE = (REG_W < 5);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_b;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd_f   = inst[11:7];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];

    assign imm_i = {{(DATA_W-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(DATA_W-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(DATA_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[DATA_W-1:12], 12'b0};
    assign imm_j = {{(DATA_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign rd  = rd_f[REG_W-1:0];
    assign rs1 = rs1_f[REG_W-1:0];
    assign rs2 = rs2_f[REG_W-1:0];

    alu_op_e    alu;
    logic [7:0] ctl_raw;
    logic       wen_raw;
    logic       bad;
    logic       use_rd;
    logic       use_rs1;
    logic       use_rs2;

    always_comb begin
        alu     = AluAdd;
        imm     = '0;
        ctl_raw = '0;
        wen_raw = 1'b0;
        bad     = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm = imm_u; alu = AluLui; wen_raw = 1'b1; use_rd = 1'b1;
            end
            OPC_AUIPC: begin
                imm = imm_u; ctl_raw[CTL_AUIPC] = 1'b1; wen_raw = 1'b1; use_rd = 1'b1;
            end
            OPC_JAL: begin
                imm = imm_j; ctl_raw[CTL_JAL] = 1'b1; wen_raw = 1'b1; use_rd = 1'b1;
            end
            OPC_JALR: begin
                imm = imm_i; ctl_raw[CTL_JALR] = 1'b1; wen_raw = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm = imm_b; ctl_raw[CTL_BRANCH] = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
                bad = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                imm = imm_i; ctl_raw[CTL_LOAD] = 1'b1; wen_raw = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
                bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                imm = imm_s; ctl_raw[CTL_STORE] = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                bad = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                imm = imm_i; wen_raw = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                alu = alu_from_funct(funct3, (funct3 == 3'b101) && inst[30]);
                if (funct3 == 3'b001) bad = (funct7 != 7'b0000000);
                if (funct3 == 3'b101) bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                wen_raw = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu = alu_from_funct(funct3, inst[30]);
                bad = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_SYSTEM: begin
                imm = imm_i;
                if (inst[31:0] == 32'h0000_0073)      ctl_raw[CTL_ECALL]  = 1'b1;
                else if (inst[31:0] == 32'h0010_0073) ctl_raw[CTL_EBREAK] = 1'b1;
                else                                  bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // RV32E only has x0..x15; any referenced index with bit 4 set cannot be encoded.
        if (RvE) begin
            bad = bad | (use_rd & rd_f[4]) | (use_rs1 & rs1_f[4]) | (use_rs2 & rs2_f[4]);
        end
    end

    assign alu_op  = alu;
    assign illegal = bad;
    assign wen     = wen_raw && !bad && (rd_f != 5'd0);
    assign ctl     = bad ? 8'h00 : ctl_raw;

endmodule

// File: rtl/ysyx_idu.sv
// Decode stage: one-entry pipeline slot between IFU and EXU with flush support.
// Decoded fields are driven combinationally from the held instruction.
module ysyx_idu
    import ysyx_idu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              next_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [REG_W-1:0]  rs1_o,
    output logic [REG_W-1:0]  rs2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [3:0]        alu_op_o,
    output logic [2:0]        funct3_o,
    output logic              wen_o,
    output logic [7:0]        ctl_o,
    output logic              illegal_o
);

    logic [0:0]        state_q;
    logic [DATA_W-1:0] inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic              full;
    logic              accept;
    logic              handoff;

    assign full    = (state_q == ST_FULL);
    assign ready_o = !full || next_ready;
    assign accept  = prev_valid && ready_o && !flush_i;
    assign handoff = full && next_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
        end else if (accept) begin
            state_q <= ST_FULL;
            inst_q  <= inst;
            pc_q    <= pc;
        end else if (handoff) begin
            state_q <= ST_EMPTY;
        end
    end

    logic [REG_W-1:0]  dec_rd;
    logic [REG_W-1:0]  dec_rs1;
    logic [REG_W-1:0]  dec_rs2;
    logic [DATA_W-1:0] dec_imm;
    logic [3:0]        dec_alu;
    logic [2:0]        dec_f3;
    logic              dec_wen;
    logic [7:0]        dec_ctl;
    logic              dec_illegal;

    ysyx_idu_dec #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_dec (
        .inst    (inst_q),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .alu_op  (dec_alu),
        .funct3  (dec_f3),
        .wen     (dec_wen),
        .ctl     (dec_ctl),
        .illegal (dec_illegal)
    );

    // Outputs read as zero whenever the slot is empty, so a stale entry never leaks out.
    assign valid_o   = full;
    assign pc_o      = full ? pc_q : '0;
    assign inst_o    = full ? inst_q : '0;
    assign rd_o      = full ? dec_rd : '0;
    assign rs1_o     = full ? dec_rs1 : '0;
    assign rs2_o     = full ? dec_rs2 : '0;
    assign imm_o     = full ? dec_imm : '0;
    assign alu_op_o  = full ? dec_alu : '0;
    assign funct3_o  = full ? dec_f3 : '0;
    assign wen_o     = full && dec_wen;
    assign ctl_o     = full ? dec_ctl : '0;
    assign illegal_o = full && dec_illegal;

endmodule

// File: tb/tb_ysyx_idu.sv
// Directed self-checking bench for ysyx_idu: decode vectors, stall, back-to-back, flush, reset.
module tb_ysyx_idu;

    logic        clk;
    logic        rst;
    logic        prev_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush_i;
    logic        next_ready;

    logic        ready_o, valid_o, wen_o, illegal_o;
    logic [31:0] pc_o, inst_o, imm_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic [7:0]  ctl_o;

    logic        e_ready, e_valid, e_wen, e_illegal;
    logic [31:0] e_pc, e_inst, e_imm;
    logic [3:0]  e_rd, e_rs1, e_rs2;
    logic [3:0]  e_alu;
    logic [2:0]  e_f3;
    logic [7:0]  e_ctl;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_BEQ   = 32'hFE20_8EE3;
    localparam logic [31:0] I_LUI   = 32'h1234_52B7;
    localparam logic [31:0] I_EBRK  = 32'h0010_0073;
    localparam logic [31:0] I_ADD16 = 32'h0010_0813;

    ysyx_idu #(.ADDR_W(32), .DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o), .inst(inst),
        .pc(pc), .flush_i(flush_i), .valid_o(valid_o), .next_ready(next_ready), .pc_o(pc_o),
        .inst_o(inst_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o),
        .alu_op_o(alu_op_o), .funct3_o(funct3_o), .wen_o(wen_o), .ctl_o(ctl_o),
        .illegal_o(illegal_o)
    );

    ysyx_idu #(.ADDR_W(32), .DATA_W(32), .REG_W(4)) dut_e (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(e_ready), .inst(inst),
        .pc(pc), .flush_i(flush_i), .valid_o(e_valid), .next_ready(next_ready), .pc_o(e_pc),
        .inst_o(e_inst), .rd_o(e_rd), .rs1_o(e_rs1), .rs2_o(e_rs2), .imm_o(e_imm),
        .alu_op_o(e_alu), .funct3_o(e_f3), .wen_o(e_wen), .ctl_o(e_ctl),
        .illegal_o(e_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction with the EXU ready; afterwards the entry sits on the outputs.
    task automatic offer(input logic [31:0] i, input logic [31:0] p);
        prev_valid = 1'b1;
        inst       = i;
        pc         = p;
        next_ready = 1'b1;
        tick();
        prev_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; prev_valid = 1'b0; inst = '0; pc = '0; flush_i = 1'b0; next_ready = 1'b0;
        tick();
        tick();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", ready_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%08h exp=0", pc_o); end
        checks++; if (imm_o !== 32'h0) begin failures++; $display("FAIL reset_imm got=%08h exp=0", imm_o); end
        checks++; if ({wen_o, illegal_o, ctl_o} !== 10'h0) begin failures++; $display("FAIL reset_ctl got=%03h exp=0", {wen_o, illegal_o, ctl_o}); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        offer(I_ADDI, 32'h8000_0000);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", valid_o); end
        checks++; if (rd_o !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", rd_o); end
        checks++; if (rs1_o !== 5'd0) begin failures++; $display("FAIL addi_rs1 got=%0d exp=0", rs1_o); end
        checks++; if (imm_o !== 32'd5) begin failures++; $display("FAIL addi_imm got=%08h exp=5", imm_o); end
        checks++; if (alu_op_o !== 4'd0) begin failures++; $display("FAIL addi_alu got=%0d exp=0", alu_op_o); end
        checks++; if (wen_o !== 1'b1) begin failures++; $display("FAIL addi_wen got=%0h exp=1", wen_o); end
        checks++; if (pc_o !== 32'h8000_0000) begin failures++; $display("FAIL addi_pc got=%08h exp=80000000", pc_o); end
        checks++; if ({illegal_o, ctl_o} !== 9'h0) begin failures++; $display("FAIL addi_ctl got=%03h exp=0", {illegal_o, ctl_o}); end
    endtask

    task automatic test_branch();
        offer(I_BEQ, 32'h8000_0004);
        checks++; if (ctl_o !== 8'h20) begin failures++; $display("FAIL beq_ctl got=%02h exp=20", ctl_o); end
        checks++; if (rs1_o !== 5'd1 || rs2_o !== 5'd2) begin failures++; $display("FAIL beq_rs got=%0d,%0d exp=1,2", rs1_o, rs2_o); end
        checks++; if (imm_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL beq_imm got=%08h exp=fffffffc", imm_o); end
        checks++; if (funct3_o !== 3'd0) begin failures++; $display("FAIL beq_f3 got=%0d exp=0", funct3_o); end
        checks++; if (wen_o !== 1'b0) begin failures++; $display("FAIL beq_wen got=%0h exp=0", wen_o); end
    endtask

    task automatic test_lui_ebreak();
        offer(I_LUI, 32'h8000_0008);
        checks++; if (imm_o !== 32'h1234_5000) begin failures++; $display("FAIL lui_imm got=%08h exp=12345000", imm_o); end
        checks++; if (rd_o !== 5'd5) begin failures++; $display("FAIL lui_rd got=%0d exp=5", rd_o); end
        checks++; if (alu_op_o !== 4'd10) begin failures++; $display("FAIL lui_alu got=%0d exp=10", alu_op_o); end
        checks++; if (wen_o !== 1'b1) begin failures++; $display("FAIL lui_wen got=%0h exp=1", wen_o); end
        offer(I_EBRK, 32'h8000_000C);
        checks++; if (ctl_o !== 8'h02) begin failures++; $display("FAIL ebreak_ctl got=%02h exp=02", ctl_o); end
        checks++; if ({wen_o, illegal_o} !== 2'b00) begin failures++; $display("FAIL ebreak_flags got=%0h exp=0", {wen_o, illegal_o}); end
    endtask

    task automatic test_illegal();
        offer(32'h0, 32'h8000_0010);
        checks++; if ({valid_o, illegal_o} !== 2'b11) begin failures++; $display("FAIL zero_illegal got=%0h exp=3", {valid_o, illegal_o}); end
        checks++; if ({wen_o, ctl_o} !== 9'h0) begin failures++; $display("FAIL zero_ctl got=%03h exp=0", {wen_o, ctl_o}); end
        offer(I_ADD16, 32'h8000_0014);
        checks++; if ({e_valid, e_illegal, e_wen} !== 3'b110) begin failures++; $display("FAIL rv32e_x16 got=%0h exp=6", {e_valid, e_illegal, e_wen}); end
        checks++; if ({illegal_o, wen_o, rd_o} !== {1'b0, 1'b1, 5'd16}) begin failures++; $display("FAIL rv32i_x16 got=%02h exp=30", {illegal_o, wen_o, rd_o}); end
        tick();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0h exp=0", valid_o); end
    endtask

    task automatic test_back_to_back();
        next_ready = 1'b0; prev_valid = 1'b1; inst = I_ADDI; pc = 32'h100;
        tick();
        inst = I_LUI; pc = 32'h104;
        #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0h exp=0", ready_o); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || inst_o !== I_ADDI || pc_o !== 32'h100 || imm_o !== 32'd5 || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%0h/%08h/%08h/%08h/%0h exp=1/%08h/100/5/0",
                         k, valid_o, inst_o, pc_o, imm_o, ready_o, I_ADDI);
            end
        end
        next_ready = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0h exp=1", ready_o); end
        tick();
        prev_valid = 1'b0;
        checks++; if (valid_o !== 1'b1 || inst_o !== I_LUI || pc_o !== 32'h104) begin failures++; $display("FAIL b2b_entry got=%0h/%08h/%08h exp=1/%08h/104", valid_o, inst_o, pc_o, I_LUI); end
        tick();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h exp=0", valid_o); end
    endtask

    task automatic test_flush();
        next_ready = 1'b0; prev_valid = 1'b1; inst = I_ADDI; pc = 32'h200;
        tick();
        inst = I_LUI; pc = 32'h204; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; prev_valid = 1'b0;
        checks++; if ({valid_o, ready_o} !== 2'b01) begin failures++; $display("FAIL flush_state got=%0h exp=1", {valid_o, ready_o}); end
        tick();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_not_taken got=%0h exp=0", valid_o); end
    endtask

    task automatic test_reset_mid();
        next_ready = 1'b0; prev_valid = 1'b1; inst = I_ADDI; pc = 32'h300;
        tick();
        prev_valid = 1'b0; rst = 1'b1; flush_i = 1'b1;
        tick();
        rst = 1'b0; flush_i = 1'b0;
        checks++; if ({valid_o, ready_o} !== 2'b01) begin failures++; $display("FAIL rstmid_state got=%0h exp=1", {valid_o, ready_o}); end
        checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%08h/%08h exp=0/0", pc_o, inst_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_lui_ebreak();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
